// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down-counter timer and its sibling counter blocks.
package down_counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Decrements on qualified ticks while running and pulses tc for one cycle at terminal count.
module down_counter
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] reload_reg;

   // busy is a pure decode of the state register, so it stays glitch-free and registered.
   assign busy = (state == RUN);

   // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         Q          <= '0;
         reload_reg <= '0;
         state      <= IDLE;
         tc         <= 1'b0;
      end else begin
         // tc defaults low on every edge, which makes it a single-cycle pulse.
         tc <= 1'b0;
         if (load) begin
            reload_reg <= load_val;
            Q          <= load_val;
            state      <= IDLE;
         end else if (stop) begin
            state <= IDLE;
         end else if (start && (state == IDLE)) begin
            if (Q != '0) state <= RUN;
         end else if ((state == RUN) && tick) begin
            if (Q == ONE) begin
               tc <= 1'b1;
               if (auto_reload) begin
                  Q <= reload_reg;
               end else begin
                  Q     <= '0;
                  state <= IDLE;
               end
            end else if (Q != '0) begin
               Q <= Q - ONE;
            end
         end
      end
   end

endmodule : down_counter

// File: doc/down_counter.md
Name: down_counter

Overview:
- Synchronous, loadable down-counter/timer. It is the count-down counterpart to the team's ripple up-counter.
- Software or stimulus loads a start value. The block decrements it on qualified ticks and flags the terminal count.
- Supports one-shot mode and auto-reload (periodic) mode.
- Used as a programmable interval timer next to the existing counter blocks.

Parameters:
- WIDTH, 4, bit width of the count and load value.

Ports:
- clock  input  1  rising-edge clock; single clock domain.
- clear_n  input  1  asynchronous, active-low reset.
- load  input  1  load strobe; captures load_val.
- load_val  input  WIDTH  start/reload value.
- start  input  1  begin counting (1-cycle pulse or level).
- stop  input  1  abort counting; Q is held.
- tick  input  1  count enable strobe (prescaler output); one decrement per sampled tick.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
- Q  output  WIDTH  current count.
- busy  output  1  1 while in RUN.
- tc  output  1  terminal-count pulse, exactly 1 cycle wide.

Behaviour:
- Reset: clear_n low asynchronously forces these values, regardless of clock:
  - Q = 0, internal reload_reg = 0, state = IDLE, busy = 0, tc = 0.
- Reset release is synchronous: the first active edge is the first rising clock with clear_n high.
- All outputs are registered. busy is high exactly when state == RUN.
- States: IDLE and RUN (2-state FSM).
- Per-edge priority, highest first: load > stop > start > tick.
- load, in any state:
  - reload_reg <= load_val, Q <= load_val, state <= IDLE, tc <= 0.
  - Loading mid-run aborts the run with no tc.
- stop in RUN: state <= IDLE, Q held, no tc. stop in IDLE has no effect.
- start in IDLE:
  - If Q != 0: state <= RUN, so busy rises one cycle after start.
  - If Q == 0: ignored; stays IDLE, no tc.
- start in RUN: ignored; no restart.
- tick is ignored in IDLE. A tick sampled on the same edge as start is ignored; the first decrement needs a tick on a later edge.
- RUN, tick=1, Q > 1: Q <= Q - 1.
- RUN, tick=1, Q == 1:
  - tc <= 1 for the next cycle only.
  - If auto_reload = 0: Q <= 0, state <= IDLE, so busy falls in the same cycle tc is high.
  - If auto_reload = 1: Q <= reload_reg and stay in RUN. The period is reload_reg ticks, and Q never shows 0 in this mode.
- RUN, tick=0: Q held.
- auto_reload is sampled only at the Q == 1 decrement edge. Changing it mid-run affects only the next terminal count.
- tc is 0 on every cycle not immediately following a terminal decrement. Back-to-back tc (pulse every cycle) is legal when reload_reg = 1 and tick is held high.
- Arithmetic is unsigned, WIDTH bits. Q never wraps below 0; the 1 -> reload / 1 -> 0 rule replaces any decrement from 0.
- Maximum count is 2^WIDTH - 1.
- Reset asserted mid-run returns the block to the reset values immediately. tc is cut short if active.

Decomposition:
- Shared package (down_counter_pkg) holds:
  - the state typedef {IDLE, RUN};
  - a default WIDTH constant shared with the up-counter bench.
- No sub-module: FSM plus datapath is a single module. The tick prescaler stays external.

Test Plan:
- Reset: hold clear_n = 0 with random inputs toggling -> Q = 0, busy = 0, tc = 0; assert clear_n mid-cycle -> outputs clear without a clock edge.
- One-shot: load 3, start, tick held 1, auto_reload 0 -> busy 1 from the cycle after start; Q 3,2,1,0; tc high 1 cycle together with Q = 0 and busy = 0.
- Auto-reload: load 2, auto_reload 1, start, tick every cycle -> Q 2,1,2,1,...; tc pulse every 2 cycles; busy stays 1 until stop.
- Sparse ticks: load 15, tick every 3rd cycle -> Q decrements only on tick edges; tc after 15 ticks (45 cycles).
- Priority and abort:
  - load 5 mid-run at Q = 2 -> Q = 5, IDLE, no tc.
  - stop at Q = 4 -> Q holds 4, busy 0.
  - load + stop + start + tick on the same edge -> load wins.
- Boundaries:
  - start with Q = 0 -> ignored, busy stays 0.
  - load 1, auto_reload 1, tick held -> tc high every cycle, Q = 1 constant.
  - clear_n pulsed mid-run -> all reset values.
